// File: rtl/fruta_gen_if.sv
// Fruit-request port between the update engine (master) and fruta_gen (slave),
// including the shared map-memory read port.
interface fruta_gen_if;
    logic       fruta_enable;
    logic       fruta_wenable;
    logic [9:0] fruta_wx;
    logic [9:0] fruta_wy;
    logic       fruta_fail;
    logic       map_renable;
    logic [9:0] map_rx;
    logic [9:0] map_ry;
    logic [1:0] map_rdata;

    modport slave (
        input  fruta_enable, map_rdata,
        output fruta_wenable, fruta_wx, fruta_wy, fruta_fail,
        output map_renable, map_rx, map_ry
    );

    modport master (
        output fruta_enable, map_rdata,
        input  fruta_wenable, fruta_wx, fruta_wy, fruta_fail,
        input  map_renable, map_rx, map_ry
    );
endinterface

// File: rtl/fruta_gen.sv
// fruta_gen: places a fruit on an empty map cell drawn from a free-running LFSR.
// Define FRUTA_LINEAR_FALLBACK_EN to add a row-major scan after MAX_TRIES misses.
module fruta_gen #(
    parameter int          MAPA_WIDTH  = 40,
    parameter int          MAPA_HEIGHT = 30,
    parameter int          X_BITS      = 6,
    parameter int          Y_BITS      = 5,
    parameter int          MAX_TRIES   = 64,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic        clk,
    input logic        reset,
    fruta_gen_if.slave bus
);
    // state   | meaning
    // IDLE    | waiting for a request
    // SORTEIA | draw candidate from LFSR, reject if off-map
    // LE      | map read strobe for the candidate
    // CHECA   | inspect map_rdata, accept or retry
    // VARRE   | start linear scan at (0,0) (fallback builds only)
    typedef enum logic [2:0] {
        IDLE, SORTEIA, LE, CHECA
`ifdef FRUTA_LINEAR_FALLBACK_EN
        , VARRE
`endif
    } state_t;

    localparam logic [9:0] X_LAST = 10'(MAPA_WIDTH - 1);
    localparam logic [9:0] Y_LAST = 10'(MAPA_HEIGHT - 1);

    state_t      state, state_n;
    logic [15:0] lfsr;
    logic [9:0]  cand_x, cand_y, cand_x_n, cand_y_n;
    logic [9:0]  wx, wy, wx_n, wy_n;
    logic        wen, wen_n;
    logic [9:0]  lfsr_x, lfsr_y;
    logic        in_range;

    assign lfsr_x   = 10'(lfsr[X_BITS-1:0]);
    assign lfsr_y   = 10'(lfsr[8+Y_BITS-1:8]);
    assign in_range = (lfsr_x <= X_LAST) && (lfsr_y <= Y_LAST);

`ifdef FRUTA_LINEAR_FALLBACK_EN
    localparam int                 TRIES_W   = $clog2(MAX_TRIES + 1);
    localparam logic [TRIES_W-1:0] TRIES_MAX = TRIES_W'(MAX_TRIES);

    logic [TRIES_W-1:0] tries, tries_n, tries_inc;
    logic               varrendo, varrendo_n;
    logic               fail, fail_n;

    assign tries_inc      = (tries >= TRIES_MAX) ? tries : tries + 1'b1;
    assign bus.fruta_fail = fail;
`else
    assign bus.fruta_fail = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            lfsr   <= LFSR_SEED;
            cand_x <= '0;
            cand_y <= '0;
            wx     <= '0;
            wy     <= '0;
            wen    <= 1'b0;
`ifdef FRUTA_LINEAR_FALLBACK_EN
            tries    <= '0;
            varrendo <= 1'b0;
            fail     <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            lfsr   <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            cand_x <= cand_x_n;
            cand_y <= cand_y_n;
            wx     <= wx_n;
            wy     <= wy_n;
            wen    <= wen_n;
`ifdef FRUTA_LINEAR_FALLBACK_EN
            tries    <= tries_n;
            varrendo <= varrendo_n;
            fail     <= fail_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        cand_x_n = cand_x;
        cand_y_n = cand_y;
        wx_n     = wx;
        wy_n     = wy;
        wen_n    = 1'b0;
`ifdef FRUTA_LINEAR_FALLBACK_EN
        tries_n    = tries;
        varrendo_n = varrendo;
        fail_n     = fail;
`endif
        case (state)
            IDLE: begin
                if (bus.fruta_enable) begin
                    state_n = SORTEIA;
`ifdef FRUTA_LINEAR_FALLBACK_EN
                    tries_n    = '0;
                    varrendo_n = 1'b0;
                    fail_n     = 1'b0;
`endif
                end
            end
            SORTEIA: begin
                if (in_range) begin
                    cand_x_n = lfsr_x;
                    cand_y_n = lfsr_y;
                    state_n  = LE;
                end
`ifdef FRUTA_LINEAR_FALLBACK_EN
                else tries_n = tries_inc;
                if (tries >= TRIES_MAX) state_n = VARRE;
`endif
            end
            LE: state_n = CHECA;
            CHECA: begin
                if (bus.map_rdata == 2'b00) begin
                    wx_n    = cand_x;
                    wy_n    = cand_y;
                    wen_n   = 1'b1;
                    state_n = IDLE;
                end
`ifdef FRUTA_LINEAR_FALLBACK_EN
                else if (varrendo) begin
                    if (cand_x == X_LAST && cand_y == Y_LAST) begin
                        wx_n    = '0;
                        wy_n    = '0;
                        fail_n  = 1'b1;
                        wen_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        if (cand_x == X_LAST) begin
                            cand_x_n = '0;
                            cand_y_n = cand_y + 10'd1;
                        end else begin
                            cand_x_n = cand_x + 10'd1;
                        end
                        state_n = LE;
                    end
                end else if (tries_inc >= TRIES_MAX) begin
                    tries_n = tries_inc;
                    state_n = VARRE;
                end
`endif
                else begin
`ifdef FRUTA_LINEAR_FALLBACK_EN
                    tries_n = tries_inc;
`endif
                    // Redraw from this cycle's LFSR so an occupied cell costs two cycles.
                    if (in_range) begin
                        cand_x_n = lfsr_x;
                        cand_y_n = lfsr_y;
                        state_n  = LE;
                    end else begin
                        state_n = SORTEIA;
                    end
                end
            end
`ifdef FRUTA_LINEAR_FALLBACK_EN
            VARRE: begin
                cand_x_n   = '0;
                cand_y_n   = '0;
                varrendo_n = 1'b1;
                state_n    = LE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    assign bus.fruta_wenable = wen;
    assign bus.fruta_wx      = wx;
    assign bus.fruta_wy      = wy;
    assign bus.map_renable   = (state == LE);
    assign bus.map_rx        = cand_x;
    assign bus.map_ry        = cand_y;
endmodule

// File: tb/tb_fruta_gen.sv
// Self-checking bench for fruta_gen: behavioural map memory, LFSR sequence model,
// randomized maps and directed handshake/reset scenarios.
`timescale 1ns/1ps
module tb_fruta_gen;
    localparam int          W         = 40;
    localparam int          H         = 30;
    localparam int          MAXT      = 64;
    localparam int          LAT_BOUND = 2*MAXT + 2*W*H + 4;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    fruta_gen_if bus();
    fruta_gen dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [1:0]  mem [0:H-1][0:W-1];
    logic [15:0] m_lfsr;
    int          n_chk   = 0;
    int          n_pass  = 0;
    int          n_wen   = 0;
    int          n_reads = 0;
    int          n_dbl   = 0;
    logic [9:0]  rd_x    = '0;
    logic [9:0]  rd_y    = '0;
    logic        prev_ren = 1'b0;

    // Sequence polynomial x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk) begin
        m_lfsr <= reset ? lfsr_next(m_lfsr) : SEED;
        if (bus.map_renable === 1'b1 && int'(bus.map_rx) < W && int'(bus.map_ry) < H)
            bus.map_rdata <= mem[int'(bus.map_ry)][int'(bus.map_rx)];
        else
            bus.map_rdata <= 2'b11;
    end

    always @(negedge clk) begin
        if (bus.fruta_wenable === 1'b1) n_wen <= n_wen + 1;
        if (bus.map_renable === 1'b1) begin
            n_reads <= n_reads + 1;
            rd_x    <= bus.map_rx;
            rd_y    <= bus.map_ry;
            if (prev_ren) n_dbl <= n_dbl + 1;
        end
        prev_ren <= (bus.map_renable === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic fill(input int mode);
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                case (mode)
                    0:       mem[yy][xx] = 2'b00;
                    1:       mem[yy][xx] = 2'b01;
                    2:       mem[yy][xx] = 2'b11;
                    default: mem[yy][xx] = 2'($urandom_range(0, 3));
                endcase
        if (mode == 1) mem[H-1][W-1] = 2'b00;
        if (mode == 3) mem[$urandom_range(0, H-1)][$urandom_range(0, W-1)] = 2'b00;
    endtask

    // Issue one request pulse and check the completed answer against the map model.
    task automatic req_check(input string tag, input bit exp_fail, input bit empty_map,
                             output logic [9:0] x, output logic [9:0] y);
        int         lat;
        int         n0;
        bit         got;
        bit         ok;
        logic [9:0] px, py;
        logic       f;
        x  = '0;
        y  = '0;
        f  = 1'b0;
        n0 = n_wen;
        bus.fruta_enable = 1'b1;
        tick();
        bus.fruta_enable = 1'b0;
        chk({tag, "_fail_clr"}, 32'(bus.fruta_fail), 0);
        px  = {4'b0, m_lfsr[5:0]};
        py  = {5'b0, m_lfsr[12:8]};
        got = 1'b0;
        lat = 1;
        while (!got && lat <= LAT_BOUND) begin
            if (bus.fruta_wenable === 1'b1) begin
                got = 1'b1;
                x   = bus.fruta_wx;
                y   = bus.fruta_wy;
                f   = bus.fruta_fail;
            end else begin
                tick();
                lat++;
            end
        end
        chk({tag, "_done"}, 32'(got), 1);
        if (got) begin
            if (empty_map && int'(px) < W && int'(py) < H) begin
                chk({tag, "_lat4"}, lat, 4);
                chk({tag, "_x_pred"}, 32'(x), 32'(px));
                chk({tag, "_y_pred"}, 32'(y), 32'(py));
            end
            chk({tag, "_fail"}, 32'(f), 32'(exp_fail));
            if (exp_fail) begin
                chk({tag, "_fail_x0"}, 32'(x), 0);
                chk({tag, "_fail_y0"}, 32'(y), 0);
            end else begin
                ok = int'(x) < W && int'(y) < H;
                chk({tag, "_range"}, 32'(ok), 1);
                if (ok) chk({tag, "_cell_empty"}, 32'(mem[int'(y)][int'(x)]), 0);
                chk({tag, "_read_x"}, 32'(rd_x), 32'(x));
                chk({tag, "_read_y"}, 32'(rd_y), 32'(y));
            end
            repeat (5) tick();
            chk({tag, "_one_pulse"}, n_wen - n0, 1);
            chk({tag, "_hold_x"}, 32'(bus.fruta_wx), 32'(x));
            chk({tag, "_hold_y"}, 32'(bus.fruta_wy), 32'(y));
            chk({tag, "_idle_ren"}, 32'(bus.map_renable), 0);
        end
        chk({tag, "_ren_1cyc"}, n_dbl, 0);
    endtask

    initial begin
        logic [9:0] x, y;
        int         n0, k;
        bus.fruta_enable = 1'b0;
        fill(0);

        // reset held for three edges, then released with no request
        repeat (3) tick();
        chk("rst_wen", 32'(bus.fruta_wenable), 0);
        chk("rst_wx", 32'(bus.fruta_wx), 0);
        chk("rst_wy", 32'(bus.fruta_wy), 0);
        chk("rst_fail", 32'(bus.fruta_fail), 0);
        chk("rst_ren", 32'(bus.map_renable), 0);
        chk("rst_rx", 32'(bus.map_rx), 0);
        chk("rst_ry", 32'(bus.map_ry), 0);
        reset = 1'b1;
        tick();
        chk("rel_wen", 32'(bus.fruta_wenable), 0);
        chk("rel_ren", 32'(bus.map_renable), 0);
        repeat (100) tick();
        chk("idle_no_reads", n_reads, 0);
        chk("idle_no_done", n_wen, 0);

        // empty map, random idle gaps shift the LFSR phase
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 15)) tick();
            req_check("empty", 1'b0, 1'b1, x, y);
        end

        // random maps with at least one empty cell
        for (int i = 0; i < 3; i++) begin
            fill(3);
            repeat ($urandom_range(0, 7)) tick();
            req_check("rand", 1'b0, 1'b0, x, y);
        end

`ifdef FRUTA_LINEAR_FALLBACK_EN
        fill(1);
        req_check("last_cell", 1'b0, 1'b0, x, y);
        chk("last_cell_x", 32'(x), W - 1);
        chk("last_cell_y", 32'(y), H - 1);

        fill(2);
        req_check("all_obst", 1'b1, 1'b0, x, y);
        chk("all_obst_fail_held", 32'(bus.fruta_fail), 1);

        fill(0);
        req_check("after_fail", 1'b0, 1'b1, x, y);
`endif

        // second request one cycle after the first is ignored
        fill(0);
        n0 = n_wen;
        bus.fruta_enable = 1'b1;
        tick();
        tick();
        bus.fruta_enable = 1'b0;
        k = 0;
        while (bus.fruta_wenable !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("dbl_done", 32'(bus.fruta_wenable), 1);
        repeat (10) tick();
        chk("dbl_one_pulse", n_wen - n0, 1);
        chk("dbl_idle_ren", 32'(bus.map_renable), 0);
        chk("dbl_idle_wen", 32'(bus.fruta_wenable), 0);

        // reset asserted while the candidate is being checked
        bus.fruta_enable = 1'b1;
        tick();
        bus.fruta_enable = 1'b0;
        k = 0;
        while (bus.map_renable !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        chk("abort_le_seen", 32'(bus.map_renable), 1);
        tick();
        reset = 1'b0;
        n0 = n_wen;
        tick();
        chk("abort_wen", 32'(bus.fruta_wenable), 0);
        chk("abort_wx", 32'(bus.fruta_wx), 0);
        chk("abort_wy", 32'(bus.fruta_wy), 0);
        chk("abort_fail", 32'(bus.fruta_fail), 0);
        chk("abort_ren", 32'(bus.map_renable), 0);
        chk("abort_rx", 32'(bus.map_rx), 0);
        reset = 1'b1;
        repeat (10) tick();
        chk("abort_no_done", n_wen - n0, 0);
        req_check("post_abort", 1'b0, 1'b1, x, y);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fruta_gen.md
Name: fruta_gen

Overview:
- Responder on the fruit-request interface driven by the game update engine.
- On a one-cycle request, it draws pseudo-random map coordinates from a free-running LFSR.
- It reads the map memory to confirm the cell is empty (00), then returns the coordinates with a one-cycle done pulse.
- It sits beside the map memory, sharing a read port with the update engine, and feeds the fruit position back to it.

Parameters:
- MAPA_WIDTH, 40, map columns; legal x is 0..MAPA_WIDTH-1.
- MAPA_HEIGHT, 30, map rows; legal y is 0..MAPA_HEIGHT-1.
- X_BITS, 6, LFSR bits used for the x candidate; must satisfy 2^X_BITS >= MAPA_WIDTH.
- Y_BITS, 5, LFSR bits used for the y candidate; must satisfy 2^Y_BITS >= MAPA_HEIGHT.
- MAX_TRIES, 64, random candidates tried before falling back to a scan.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- fruta_enable  in  1  request pulse; sampled only in IDLE.
- fruta_wenable  out  1  done pulse; 1 cycle, fruta_wx/fruta_wy valid.
- fruta_wx  out  10  fruit x; held stable until the next done pulse.
- fruta_wy  out  10  fruit y; held stable until the next done pulse.
- fruta_fail  out  1  set with done when no empty cell exists; cleared on next request.
- map_renable  out  1  map read strobe.
- map_rx  out  10  map read x.
- map_ry  out  10  map read y.
- map_rdata  in  2  cell code, valid the cycle after map_renable. Codes: 00 empty, 01 snake, 10 fruit, 11 obstacle.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; LFSR=LFSR_SEED; tries=0.
  - All outputs 0.
  - Reset overrides everything, including an in-flight search; no done pulse is issued for an aborted request.
- LFSR:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Advances every cycle outside reset, regardless of state.
- States:
  - IDLE:
    - fruta_wenable=0, map_renable=0.
    - If fruta_enable: tries=0, fruta_fail=0, go to SORTEIA.
  - SORTEIA:
    - cand_x=LFSR[X_BITS-1:0]; cand_y=LFSR[8+Y_BITS-1:8], both zero-extended to 10 bits.
    - If cand_x>=MAPA_WIDTH or cand_y>=MAPA_HEIGHT: tries+1, stay in SORTEIA (rejection sampling; no modulo).
    - Otherwise go to LE.
  - LE:
    - map_renable=1, map_rx=cand_x, map_ry=cand_y, go to CHECA.
    - map_renable is high for exactly this cycle.
  - CHECA:
    - If map_rdata==00: register fruta_wx=cand_x, fruta_wy=cand_y, fruta_wenable=1 (visible the next cycle for one cycle), go to IDLE.
    - Otherwise: tries+1, go to SORTEIA.
  - Try limit: when tries reaches MAX_TRIES in SORTEIA or CHECA, go to VARRE (macro enabled) or keep retrying (macro disabled).
  - VARRE (fallback):
    - Starts at (0,0); row-major scan, x fastest.
    - Each cell takes an LE/CHECA pair, i.e. 2 cycles per cell.
    - First cell with rdata==00 is returned as above.
    - If the scan passes (MAPA_WIDTH-1, MAPA_HEIGHT-1) without a hit: fruta_wx=0, fruta_wy=0, fruta_fail=1, fruta_wenable=1, go to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0; first candidate in range and empty gives fruta_wenable high in cycle 4.
  - Each rejection adds 1 cycle (out of range) or 2 cycles (occupied).
- Handshake:
  - fruta_enable outside IDLE is ignored, not queued.
  - A request in the same cycle that done is registered is ignored.
  - The consumer must wait for fruta_wenable before using the coordinates.
- Arithmetic:
  - tries is a counter wide enough for MAX_TRIES; it saturates and never wraps.
  - Scan counters wrap x at MAPA_WIDTH-1 to 0 and increment y.

Optional Feature:
- FRUTA_LINEAR_FALLBACK_EN defined: the VARRE state exists; termination is guaranteed in at most 2*MAX_TRIES + 2*MAPA_WIDTH*MAPA_HEIGHT + 4 cycles; fruta_fail can assert.
- Not defined: there is no VARRE state; random retries continue indefinitely until an empty cell is found; fruta_fail is tied to 0.

Test Plan:
- Reset held 3 cycles, then released with no request -> all outputs 0; map_renable stays 0 for 100 cycles.
- Empty 40x30 map, fruta_enable pulse at cycle 0 -> fruta_wenable high only in cycle 4 when the first candidate is in range, generally within the latency bound; fruta_wx<40, fruta_wy<30; a map read occurred at the same (x,y); fruta_fail=0.
- Map all 01 except (39,29), macro enabled -> after 64 tries, fruta_wx=39, fruta_wy=29, fruta_wenable pulses once, fruta_fail=0.
- Map entirely 11, macro enabled -> fruta_wenable with fruta_fail=1 and fruta_wx=fruta_wy=0 within 2*64+2*1200+4 cycles; next request clears fruta_fail.
- Second fruta_enable pulse 1 cycle after the first -> exactly one fruta_wenable; block back in IDLE afterwards.
- reset=0 while in CHECA -> next cycle all outputs 0 and no done pulse; a fresh request afterwards completes normally.
